// File: rtl/serial_logic16.sv
// Bit-serial logic unit: one gate slice reused WIDTH times, LSB first, with valid/ready on both sides.
// Optional zero/negative result flags are built when SERIAL_LOGIC_FLAGS_EN is defined.
module serial_logic16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SERIAL_LOGIC_FLAGS_EN
    output logic             out_zr,
    output logic             out_ng,
`endif
    output logic [WIDTH-1:0] out_data
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_r, state_s;
    logic             in_ready_r, in_ready_s;
    logic             out_valid_r, out_valid_s;
    logic [WIDTH-1:0] a_sr_r, b_sr_r, res_sr_r, out_data_r;
    logic [WIDTH-1:0] res_next_s;
    logic [1:0]       op_r;
    logic [CW-1:0]    cnt_r;
    logic             and_s, nand_s, or_s, xor_s, m0_s, m1_s, bit_s;

    // Gate slice: the four ops are formed in parallel and op_r picks one through a gate-level mux tree.
    sl_and2  u_and  (.a(a_sr_r[0]), .b(b_sr_r[0]), .y(and_s));
    sl_nand2 u_nand (.a(a_sr_r[0]), .b(b_sr_r[0]), .y(nand_s));
    sl_or2   u_or   (.a(a_sr_r[0]), .b(b_sr_r[0]), .y(or_s));
    sl_xor2  u_xor  (.a(a_sr_r[0]), .b(b_sr_r[0]), .y(xor_s));
    sl_mux2  u_m0   (.s(op_r[0]), .d0(and_s), .d1(nand_s), .y(m0_s));
    sl_mux2  u_m1   (.s(op_r[0]), .d0(or_s),  .d1(xor_s),  .y(m1_s));
    sl_mux2  u_m2   (.s(op_r[1]), .d0(m0_s),  .d1(m1_s),   .y(bit_s));

    assign res_next_s = {bit_s, res_sr_r[WIDTH-1:1]};

    // State register plus the registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
        end
    end

    // Next-state logic; handshake outputs follow the state being entered.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_s = SHIFT;
                else          state_s = IDLE;
            end
            SHIFT: begin
                if (cnt_r == LAST_BIT) state_s = DONE;
                else                   state_s = SHIFT;
            end
            DONE: begin
                if (out_ready) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
        in_ready_s  = (state_s == IDLE);
        out_valid_s = (state_s == DONE);
    end

    // Operand capture, serial shifting and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r     <= {WIDTH{1'b0}};
            b_sr_r     <= {WIDTH{1'b0}};
            res_sr_r   <= {WIDTH{1'b0}};
            out_data_r <= {WIDTH{1'b0}};
            op_r       <= 2'b00;
            cnt_r      <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sr_r   <= in_a;
                        b_sr_r   <= in_b;
                        op_r     <= in_op;
                        res_sr_r <= {WIDTH{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                SHIFT: begin
                    a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
                    res_sr_r <= res_next_s;
                    // Counter ends at WIDTH on the DONE transition and holds there.
                    cnt_r    <= cnt_r + CW'(1);
                    if (cnt_r == LAST_BIT) out_data_r <= res_next_s;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

`ifdef SERIAL_LOGIC_FLAGS_EN
    logic zr_acc_r, zr_acc_s, zr_s, out_zr_r, out_ng_r;

    sl_or2 u_zr_or  (.a(zr_acc_r), .b(bit_s), .y(zr_acc_s));
    sl_not u_zr_not (.a(zr_acc_s), .y(zr_s));

    // Zero flag accumulates the OR of result bits; negative flag is the final (MSB) bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zr_acc_r <= 1'b0;
            out_zr_r <= 1'b0;
            out_ng_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) zr_acc_r <= 1'b0;
                end
                SHIFT: begin
                    zr_acc_r <= zr_acc_s;
                    if (cnt_r == LAST_BIT) begin
                        out_zr_r <= zr_s;
                        out_ng_r <= bit_s;
                    end
                end
                default: begin
                    zr_acc_r <= zr_acc_r;
                end
            endcase
        end
    end

    assign out_zr = out_zr_r;
    assign out_ng = out_ng_r;
`else
    // Default build carries no flag state.
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
endmodule

// Base primitive: every other gate below is composed from this one.
module sl_nand2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

module sl_not (
    input  logic a,
    output logic y
);
    sl_nand2 u_n (.a(a), .b(a), .y(y));
endmodule

module sl_and2 (
    input  logic a,
    input  logic b,
    output logic y
);
    logic n_s;
    sl_nand2 u_n (.a(a), .b(b), .y(n_s));
    sl_not   u_i (.a(n_s), .y(y));
endmodule

module sl_or2 (
    input  logic a,
    input  logic b,
    output logic y
);
    logic na_s, nb_s;
    sl_not   u_ia (.a(a), .y(na_s));
    sl_not   u_ib (.a(b), .y(nb_s));
    sl_nand2 u_n  (.a(na_s), .b(nb_s), .y(y));
endmodule

module sl_xor2 (
    input  logic a,
    input  logic b,
    output logic y
);
    logic n_s, na_s, nb_s;
    sl_nand2 u_n0 (.a(a),    .b(b),    .y(n_s));
    sl_nand2 u_n1 (.a(a),    .b(n_s),  .y(na_s));
    sl_nand2 u_n2 (.a(b),    .b(n_s),  .y(nb_s));
    sl_nand2 u_n3 (.a(na_s), .b(nb_s), .y(y));
endmodule

module sl_mux2 (
    input  logic s,
    input  logic d0,
    input  logic d1,
    output logic y
);
    logic ns_s, p0_s, p1_s;
    sl_not   u_is (.a(s), .y(ns_s));
    sl_nand2 u_p0 (.a(d0),   .b(ns_s), .y(p0_s));
    sl_nand2 u_p1 (.a(d1),   .b(s),    .y(p1_s));
    sl_nand2 u_o  (.a(p0_s), .b(p1_s), .y(y));
endmodule

// File: tb/tb_serial_logic16.sv
// Scoreboard bench for serial_logic16: stimulus pushes expected results, a monitor pops on each output handshake.
module tb_serial_logic16;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_op = 2'b00;
    logic [W-1:0] in_a = 16'h0000;
    logic [W-1:0] in_b = 16'h0000;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
`ifdef SERIAL_LOGIC_FLAGS_EN
    logic         out_zr, out_ng;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic        zr;
        logic        ng;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   t_acc = 0;
    int   t0 = 0;

    serial_logic16 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef SERIAL_LOGIC_FLAGS_EN
        .out_zr(out_zr), .out_ng(out_ng),
`endif
        .out_data(out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every accepted output is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%0h required=none", out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result_data", 32'(out_data), 32'(e.data));
`ifdef SERIAL_LOGIC_FLAGS_EN
                check("flag_zr", 32'(out_zr), 32'(e.zr));
                check("flag_ng", 32'(out_ng), 32'(e.ng));
`endif
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input exp_t e, input bit push);
        int n = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
        end
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        t_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!out_valid) begin
            checks++; failures++;
            $display("FAIL valid_timeout actual=out_valid_low required=out_valid_high");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'h0000);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // AND with latency and in_ready profile
        send(2'b00, 16'hF0F0, 16'hFF00, {16'hF000, 1'b0, 1'b1}, 1'b1);
        t0 = t_acc;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            check("shift_in_ready", 32'(in_ready), 32'd0);
            check("valid_latency", 32'(out_valid), (k == 16) ? 32'd1 : 32'd0);
        end

        // Back-to-back ops with out_ready high
        send(2'b01, 16'hFFFF, 16'hFFFF, {16'h0000, 1'b1, 1'b0}, 1'b1);
        check("ii_nand", 32'(t_acc - t0), 32'd18); t0 = t_acc;
        send(2'b11, 16'hAAAA, 16'hFFFF, {16'h5555, 1'b0, 1'b0}, 1'b1);
        check("ii_xor", 32'(t_acc - t0), 32'd18); t0 = t_acc;
        send(2'b10, 16'h1234, 16'h0F0F, {16'h1F3F, 1'b0, 1'b0}, 1'b1);
        check("ii_or", 32'(t_acc - t0), 32'd18);
        wait_valid();
        @(posedge clk); #1;

        // Backpressure with new operands pending
        out_ready = 1'b0;
        send(2'b00, 16'h00FF, 16'h0FF0, {16'h00F0, 1'b0, 1'b0}, 1'b1);
        wait_valid();
        in_valid = 1'b1; in_op = 2'b10; in_a = 16'h000F; in_b = 16'h00F0;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_out_data", 32'(out_data), 32'h00F0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        exp_q.push_back({16'h00FF, 1'b0, 1'b0});
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("bp_next_accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_valid();
        @(posedge clk); #1;

        // Asynchronous reset in the middle of an AND
        send(2'b00, 16'hFFFF, 16'h00FF, {16'h00FF, 1'b0, 1'b0}, 1'b0);
        repeat (8) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_data", 32'(out_data), 32'h0000);
        check("abort_in_ready", 32'(in_ready), 32'd1);
`ifdef SERIAL_LOGIC_FLAGS_EN
        check("abort_zr", 32'(out_zr), 32'd0);
        check("abort_ng", 32'(out_ng), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_valid", 32'(out_valid), 32'd0);
        send(2'b11, 16'h0F0F, 16'h00FF, {16'h0FF0, 1'b0, 1'b0}, 1'b1);
        wait_valid();
        @(posedge clk); #1;

        // in_op changes mid-shift must be ignored
        send(2'b01, 16'h0F0F, 16'h00FF, {16'hFFF0, 1'b0, 1'b1}, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        in_op = 2'b11;
        repeat (4) begin
            @(posedge clk); #1;
        end
        in_op = 2'b00;
        wait_valid();
        @(posedge clk); #1;

        // Flag-oriented vectors
        send(2'b11, 16'h8000, 16'h0000, {16'h8000, 1'b0, 1'b1}, 1'b1);
        send(2'b00, 16'h00FF, 16'hFF00, {16'h0000, 1'b1, 1'b0}, 1'b1);
        wait_valid();
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_logic16.md
Name: serial_logic16

Overview:
- Bit-serial 16-bit logic unit: reduces a word-wide gate operation to a single 1-bit gate path reused over WIDTH cycles.
- Complements the combinational gate layer. Parallel operands are serialised LSB-first through one gate slice, and the result is deserialised back into a word.
- Sits between the gate library and the future serial datapath.
- Valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  block can accept operands.
- in_op  input  2  00 AND, 01 NAND, 10 OR, 11 XOR.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result word.

Behaviour:
- Reset (async assert, sync release on clk):
  - state=IDLE; in_ready=1; out_valid=0; out_data=0.
  - Internal shift registers and bit counter = 0.
- FSM IDLE:
  - in_ready=1.
  - If in_valid: latch in_a, in_b, in_op; clear bit counter; go to SHIFT.
- FSM SHIFT:
  - in_ready=0. Each cycle, apply op to a_sr[0], b_sr[0].
  - Result bit shifts in at the MSB of the result register; a_sr and b_sr shift right.
  - Counter increments each cycle.
  - After the WIDTH-th bit, go to DONE.
- FSM DONE:
  - out_valid=1; out_data holds the result and is stable while out_valid=1.
  - If out_ready: go to IDLE and drop out_valid next cycle.
- Latency:
  - Handshake at edge N; bits processed at edges N+1..N+WIDTH; out_valid high after edge N+WIDTH.
  - Minimum initiation interval: WIDTH+2 cycles.
- Bit order: LSB first. After WIDTH shifts, result bit i maps to out_data[i].
- Op derivation:
  - The gate slice is built only from existing 1-bit gate modules (nand/not/and-level primitives). No behavioural operators on the data path.
  - in_op is sampled only at acceptance; changes mid-operation are ignored.
- Backpressure: out_ready low in DONE holds the result indefinitely. in_valid is ignored (in_ready=0) until the result is consumed.
- Simultaneous events: in DONE with out_ready=1 and in_valid=1, the new operands are NOT accepted that cycle. They are accepted in the following IDLE cycle.
- Counter: width $clog2(WIDTH+1); no wrap. It saturates at the DONE transition.
- Reset mid-operation: aborts immediately and returns to IDLE.
  - No out_valid pulse for the aborted operation.
  - Partial result discarded; out_data=0.
- out_data while out_valid=0: holds the last result (0 after reset); consumers must not sample it.

Optional Feature:
- Macro: SERIAL_LOGIC_FLAGS_EN.
- Defined:
  - Adds outputs out_zr (1: result == 0) and out_ng (result MSB), Hack-ALU style.
  - Both are computed serially during SHIFT: zr accumulates the OR of result bits; ng is the last bit shifted.
  - Both are valid and stable with out_valid and reset to 0.
- Undefined: ports absent; no flag logic synthesised; timing/handshake identical.

Test Plan:
- AND, a=0xF0F0, b=0xFF00, accepted at edge 0 -> out_valid rises after edge 16, out_data=0xF000; in_ready=0 during edges 1..16.
- NAND, 0xFFFF/0xFFFF -> out_data=0x0000; XOR, 0xAAAA/0xFFFF -> 0x5555; OR, 0x1234/0x0F0F -> 0x1F3F. Run back-to-back with out_ready=1; initiation interval = 18 cycles.
- Backpressure: out_ready=0 for 5 cycles after out_valid while in_valid=1 with new operands -> out_data stable, in_ready=0, no acceptance. out_ready=1 -> IDLE, then new operands accepted next cycle.
- Reset: assert rst_n=0 after bit 7 of an AND, asynchronously mid-cycle -> all outputs reset immediately (out_valid=0, out_data=0, in_ready=1). A fresh operation after release completes correctly.
- Op change mid-shift: in_op toggled during SHIFT -> result reflects the op latched at acceptance.
- Flags (macro on): XOR 0x8000/0x0000 -> out_ng=1, out_zr=0; AND 0x00FF/0xFF00 -> out_zr=1, out_ng=0. Macro off: bench compiles without flag ports.
